pw_phase_shift_ctrl: RTL and testbench
======================================

Name: pw_phase_shift_ctrl

Overview:
Sequences the dynamic phase-shift port of the trigger clock MMCM. This port is psen, psincdec and psdone, clocked by the USB clock.
- Register logic writes a signed target phase position and pulses go.
- The block issues one-cycle psen step pulses, one per psdone handshake, until the tracked position equals the target.
- It reports busy, done and timeout status back to the register block.

Parameters:
pSTEP_WIDTH, 11, width of signed target/position (two's complement).
pMAX_STEPS, 1023, clamp magnitude; target limited to [-pMAX_STEPS, +pMAX_STEPS].
pTIMEOUT, 64, max usb_clk cycles from psen to psdone before aborting.

Ports:
usb_clk  input  1  single clock (MMCM psclk); all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
I_target  input  pSTEP_WIDTH  signed requested phase position; sampled on I_go.
I_go  input  1  one-cycle start pulse from register block.
I_locked  input  1  MMCM locked status.
psdone  input  1  MMCM step-complete pulse.
psen  output  1  MMCM phase-shift enable; registered, high exactly 1 cycle per step.
psincdec  output  1  step direction, 1 = increment, 0 = decrement; registered.
O_position  output  pSTEP_WIDTH  signed current tracked position.
O_busy  output  1  high while a move is in progress.
O_done  output  1  one-cycle pulse when a move completes successfully.
O_timeout  output  1  sticky error flag.

Behaviour:
- Reset values: psen=0, psincdec=0, O_position=0, O_busy=0, O_done=0, O_timeout=0, state=IDLE, timeout counter=0.
- Reset mid-move aborts at once. No further psen is issued. Position returns to 0, matching the MMCM, which shares reset_i.
- States: IDLE, CHECK, PULSE, WAIT_DONE.
- IDLE:
  - On I_go, latch the clamped target: values above +pMAX_STEPS become +pMAX_STEPS, values below -pMAX_STEPS become -pMAX_STEPS.
  - On I_go, clear O_timeout, set O_busy (visible next cycle) and go to CHECK.
  - I_go in any other state is ignored; the target is not re-latched.
- CHECK:
  - If I_locked=0, stay in CHECK (hold, no pulses).
  - Else if position==target, go to IDLE, drop O_busy and pulse O_done. Both take effect on the same cycle IDLE is entered.
  - Else set psincdec = (target > position), assert psen and go to PULSE.
- PULSE:
  - Lasts one cycle; psen=1 during this cycle only. Deassert psen and go to WAIT_DONE.
  - The timeout counter starts at 1 in this cycle.
- WAIT_DONE:
  - psincdec is held stable.
  - On psdone: O_position += 1 if psincdec, else -= 1 (pSTEP_WIDTH wide, no wrap, since clamping keeps it in range). Then go to CHECK.
  - Else increment the counter. When the counter reaches pTIMEOUT without psdone: set O_timeout, drop O_busy, go to IDLE, leave position unchanged, no O_done.
  - psdone and the timeout on the same cycle: psdone wins.
- psdone received in IDLE, CHECK or PULSE is ignored; position is unchanged.
- Latency: I_go at cycle N gives O_busy=1 at N+1. The first psen is at N+2 if locked at N+1.
- Step period: (psdone delay after psen) + 2 cycles.
- Zero-length move (target==position): O_busy high 1 cycle, O_done at N+2, no psen.
- I_locked dropping during WAIT_DONE has no effect until the next CHECK, where the move holds.
- At most one outstanding psen at any time; psen never asserts two consecutive cycles.

Test Plan:
1. Reset, locked=1, target=+3, MMCM model returns psdone 12 cycles after each psen:
   - 3 psen pulses, psincdec=1 on each.
   - O_position goes 1, 2, 3.
   - O_done one pulse, O_busy low afterwards.
   - Period between psen pulses = 14 cycles.
2. From position 3, target=-2: 5 psen pulses with psincdec=0; O_position ends at -2 (0x7FE at width 11); O_done pulse.
3. Clamp: target=+1500 → latched target +1023. Abort via reset_i after 4 steps → outputs return to reset values and no further psen.
4. Timeout: the model never returns psdone after the first psen → O_timeout=1 exactly 64 cycles after psen, O_busy=0, O_position unchanged, no O_done. A new I_go clears O_timeout.
5. Locked gating: locked=0 with I_go, target=+2 → O_busy=1 and no psen for 20 cycles. Raise locked → 2 steps complete, O_position=2.
6. Protocol:
   - I_go pulsed mid-move with a different target → ignored; the original target is reached.
   - Spurious psdone in IDLE → position unchanged.
   - target==position → O_done at N+2, zero psen pulses.

Source files
------------

// File: rtl/pw_phase_shift_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | pw_phase_shift_ctrl_if : register-side and MMCM dynamic phase-shift port  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pw_phase_shift_ctrl_if #(
    parameter int pSTEP_WIDTH = 11
);
    logic signed [pSTEP_WIDTH-1:0] I_target;
    logic                          I_go;
    logic                          I_locked;
    logic                          psdone;
    logic                          psen;
    logic                          psincdec;
    logic signed [pSTEP_WIDTH-1:0] O_position;
    logic                          O_busy;
    logic                          O_done;
    logic                          O_timeout;

    modport slave (
        input  I_target, I_go, I_locked, psdone,
        output psen, psincdec, O_position, O_busy, O_done, O_timeout
    );

    modport master (
        output I_target, I_go, I_locked, psdone,
        input  psen, psincdec, O_position, O_busy, O_done, O_timeout
    );
endinterface

`default_nettype wire

// File: rtl/pw_phase_shift_ctrl.sv
// +--------------------------------------------------------------------------+
// | pw_phase_shift_ctrl : steps the MMCM phase one psen/psdone at a time      |
// | until the tracked position reaches the clamped target.                    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pw_phase_shift_ctrl #(
    parameter int pSTEP_WIDTH = 11,
    parameter int pMAX_STEPS  = 1023,
    parameter int pTIMEOUT    = 64
) (
    input  wire logic             usb_clk,
    input  wire logic             reset_i,
    pw_phase_shift_ctrl_if.slave  ps_if
);
    localparam int CW = $clog2(pTIMEOUT + 1);
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_CHECK = 2'd1;
    localparam logic [1:0] C_PULSE = 2'd2;
    localparam logic [1:0] C_WAIT  = 2'd3;
    localparam logic signed [pSTEP_WIDTH-1:0] C_MAX = pSTEP_WIDTH'(pMAX_STEPS);
    localparam logic signed [pSTEP_WIDTH-1:0] C_MIN = -C_MAX;

    logic [1:0]                    state_q,    state_d;
    logic                          psen_q,     psen_d;
    logic                          psincdec_q, psincdec_d;
    logic signed [pSTEP_WIDTH-1:0] pos_q,      pos_d;
    logic signed [pSTEP_WIDTH-1:0] target_q,   target_d;
    logic                          busy_q,     busy_d;
    logic                          done_q,     done_d;
    logic                          timeout_q,  timeout_d;
    logic [CW-1:0]                 cnt_q,      cnt_d;

    logic signed [pSTEP_WIDTH-1:0] w_target_clamped;
    logic                          w_at_target;
    logic                          w_expired;

    always_comb begin
        w_target_clamped = ps_if.I_target;
        if (ps_if.I_target > C_MAX) begin
            w_target_clamped = C_MAX;
        end else if (ps_if.I_target < C_MIN) begin
            w_target_clamped = C_MIN;
        end
    end

    assign w_at_target = (pos_q == target_q);
    assign w_expired   = (cnt_q == CW'(pTIMEOUT));

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q    <= C_IDLE;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            pos_q      <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            pos_q      <= pos_d;
            target_q   <= target_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (ps_if.I_go) state_d = C_CHECK;
            C_CHECK: if (ps_if.I_locked) state_d = w_at_target ? C_IDLE : C_PULSE;
            C_PULSE: state_d = C_WAIT;
            C_WAIT: begin
                if (ps_if.psdone) begin
                    state_d = C_CHECK;
                end else if (w_expired) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        psen_d     = 1'b0;
        done_d     = 1'b0;
        psincdec_d = psincdec_q;
        pos_d      = pos_q;
        target_d   = target_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            C_IDLE: begin
                if (ps_if.I_go) begin
                    target_d  = w_target_clamped;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            C_CHECK: begin
                if (ps_if.I_locked) begin
                    if (w_at_target) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        psincdec_d = (target_q > pos_q);
                        psen_d     = 1'b1;
                        cnt_d      = CW'(1);
                    end
                end
            end
            C_PULSE: cnt_d = cnt_q + CW'(1);
            C_WAIT: begin
                // psdone takes priority over an expiring counter
                if (ps_if.psdone) begin
                    pos_d = psincdec_q ? (pos_q + pSTEP_WIDTH'(1)) : (pos_q - pSTEP_WIDTH'(1));
                end else if (w_expired) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign ps_if.psen       = psen_q;
    assign ps_if.psincdec   = psincdec_q;
    assign ps_if.O_position = pos_q;
    assign ps_if.O_busy     = busy_q;
    assign ps_if.O_done     = done_q;
    assign ps_if.O_timeout  = timeout_q;
endmodule

`default_nettype wire

// File: tb/tb_pw_phase_shift_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pw_phase_shift_ctrl : directed vector bench with a simple MMCM model.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pw_phase_shift_ctrl;
    typedef struct {
        logic signed [10:0] tgt;
        int                 dly;
        int                 exp_pos;
        int                 exp_psen;
        bit                 dir;
        bit                 zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pw_phase_shift_ctrl_if #(.pSTEP_WIDTH(11)) i  ();
    pw_phase_shift_ctrl_if #(.pSTEP_WIDTH(12)) i2 ();

    pw_phase_shift_ctrl #(.pSTEP_WIDTH(11), .pMAX_STEPS(1023), .pTIMEOUT(64)) dut (
        .usb_clk (clk),
        .reset_i (rst),
        .ps_if   (i)
    );

    // 12-bit instance lets a +1500 request be expressed for the clamp check
    pw_phase_shift_ctrl #(.pSTEP_WIDTH(12), .pMAX_STEPS(1023), .pTIMEOUT(64)) dut2 (
        .usb_clk (clk),
        .reset_i (rst),
        .ps_if   (i2)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MMCM model: psdone arrives m_delay cycles after psen
    int   m_delay = 12;
    bit   m_en    = 1'b1;
    int   m_cd    = 0;
    logic m_done  = 1'b0;
    logic spur    = 1'b0;
    assign i.psdone = m_done | spur;
    always @(negedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_cd = 0;
        end else begin
            if (m_cd > 0) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_done = 1'b1;
            end
            if (i.psen && m_en) m_cd = m_delay;
        end
    end

    int   m2_cd   = 0;
    logic m2_done = 1'b0;
    int   psen2_cnt = 0;
    assign i2.psdone = m2_done;
    always @(negedge clk) begin
        m2_done = 1'b0;
        if (rst) begin
            m2_cd = 0;
        end else begin
            if (m2_cd > 0) begin
                m2_cd = m2_cd - 1;
                if (m2_cd == 0) m2_done = 1'b1;
            end
            if (i2.psen) begin
                m2_cd     = 1;
                psen2_cnt = psen2_cnt + 1;
            end
        end
    end

    int   psen_cnt = 0, done_cnt = 0, dir_err = 0, per_err = 0, cons_err = 0;
    int   last_psen_cyc = 0, done_cyc = 0;
    logic prev_psen = 1'b0;
    bit   exp_dir = 1'b0, chk_dir = 1'b0, chk_per = 1'b0;
    int   exp_period = 0, move_start = 0;
    always @(negedge clk) begin
        if (i.psen) begin
            psen_cnt = psen_cnt + 1;
            if (prev_psen) cons_err = cons_err + 1;
            if (chk_dir && (i.psincdec != exp_dir)) dir_err = dir_err + 1;
            if (chk_per && (last_psen_cyc > move_start) && (cyc - last_psen_cyc != exp_period))
                per_err = per_err + 1;
            last_psen_cyc = cyc;
        end
        if (i.O_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        prev_psen = i.psen;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        while (i.O_busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_idle_wait"}, longint'(i.O_busy), 0);
    endtask

    task automatic wait_psen(input int maxc, input string nm);
        int k = 0;
        while (!i.psen && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_psen_wait"}, longint'(i.psen), 1);
    endtask

    task automatic pulse_go(input logic signed [10:0] tgt);
        i.I_target = tgt;
        i.I_go     = 1'b1;
        @(negedge clk);
        i.I_go     = 1'b0;
    endtask

    task automatic run_move(input vec_t v, input int idx);
        int p0, d0, de0, pe0, ce0, g;
        m_delay = v.dly; m_en = 1'b1; i.I_locked = 1'b1;
        exp_dir = v.dir; exp_period = v.dly + 2; chk_dir = !v.zero; chk_per = 1'b1;
        @(negedge clk);
        move_start = cyc; g = cyc;
        p0 = psen_cnt; d0 = done_cnt; de0 = dir_err; pe0 = per_err; ce0 = cons_err;
        pulse_go(v.tgt);
        chk($sformatf("v%0d_busy_n1", idx), longint'(i.O_busy), 1);
        wait_idle(20000, $sformatf("v%0d", idx));
        @(negedge clk);
        chk($sformatf("v%0d_position", idx), longint'(i.O_position), v.exp_pos);
        chk($sformatf("v%0d_psen_count", idx), psen_cnt - p0, v.exp_psen);
        chk($sformatf("v%0d_dir_errors", idx), dir_err - de0, 0);
        chk($sformatf("v%0d_period_errors", idx), per_err - pe0, 0);
        chk($sformatf("v%0d_psen_consecutive", idx), cons_err - ce0, 0);
        chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
        chk($sformatf("v%0d_timeout", idx), longint'(i.O_timeout), 0);
        if (v.zero) chk($sformatf("v%0d_done_latency", idx), done_cyc - g, 2);
        chk_dir = 1'b0; chk_per = 1'b0;
    endtask

    initial begin
        vec_t tv[6];
        int p0, d0, pc, k;
        tv[0] = '{tgt: 11'sd3,    dly: 12, exp_pos: 3,     exp_psen: 3,    dir: 1'b1, zero: 1'b0};
        tv[1] = '{tgt: -11'sd2,   dly: 12, exp_pos: -2,    exp_psen: 5,    dir: 1'b0, zero: 1'b0};
        tv[2] = '{tgt: 11'sd5,    dly: 1,  exp_pos: 5,     exp_psen: 7,    dir: 1'b1, zero: 1'b0};
        tv[3] = '{tgt: 11'sd5,    dly: 3,  exp_pos: 5,     exp_psen: 0,    dir: 1'b1, zero: 1'b1};
        tv[4] = '{tgt: 11'sh400,  dly: 1,  exp_pos: -1023, exp_psen: 1028, dir: 1'b0, zero: 1'b0};
        tv[5] = '{tgt: 11'sd0,    dly: 2,  exp_pos: 0,     exp_psen: 1023, dir: 1'b1, zero: 1'b0};

        i.I_target = '0; i.I_go = 1'b0; i.I_locked = 1'b1;
        i2.I_target = '0; i2.I_go = 1'b0; i2.I_locked = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_psen",     longint'(i.psen), 0);
        chk("rst_psincdec", longint'(i.psincdec), 0);
        chk("rst_position", longint'(i.O_position), 0);
        chk("rst_busy",     longint'(i.O_busy), 0);
        chk("rst_done",     longint'(i.O_done), 0);
        chk("rst_timeout",  longint'(i.O_timeout), 0);

        for (int v = 0; v < 6; v++) run_move(tv[v], v);

        // abort by reset after four steps of a clamped -1024 request
        m_delay = 1;
        p0 = psen_cnt;
        pulse_go(11'sh400);
        k = 0;
        while (i.O_position != -11'sd4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_m4", longint'(i.O_position), -4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_psen",     longint'(i.psen), 0);
        chk("abort_position", longint'(i.O_position), 0);
        chk("abort_busy",     longint'(i.O_busy), 0);
        chk("abort_psincdec", longint'(i.psincdec), 0);
        repeat (20) @(negedge clk);
        chk("abort_psen_total", psen_cnt - p0, 4);

        // timeout: first psen never answered
        m_en = 1'b0;
        d0 = done_cnt;
        pulse_go(11'sd5);
        wait_psen(10, "to");
        pc = cyc;
        k = 0;
        while (!i.O_timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_flag",     longint'(i.O_timeout), 1);
        chk("to_latency",  cyc - pc, 64);
        chk("to_busy",     longint'(i.O_busy), 0);
        chk("to_position", longint'(i.O_position), 0);
        @(negedge clk);
        chk("to_no_done",  done_cnt - d0, 0);
        m_en = 1'b1;
        pulse_go(11'sd0);
        chk("to_cleared_by_go", longint'(i.O_timeout), 0);
        wait_idle(20, "to_clear");

        // locked gating
        m_delay = 3;
        i.I_locked = 1'b0;
        p0 = psen_cnt;
        pulse_go(11'sd2);
        repeat (20) @(negedge clk);
        chk("lock_busy_held", longint'(i.O_busy), 1);
        chk("lock_no_psen",   psen_cnt - p0, 0);
        i.I_locked = 1'b1;
        wait_idle(100, "lock");
        chk("lock_position",  longint'(i.O_position), 2);
        chk("lock_psen",      psen_cnt - p0, 2);

        // go mid-move is ignored
        m_delay = 12;
        p0 = psen_cnt;
        pulse_go(11'sd6);
        wait_psen(10, "mid");
        @(negedge clk);
        pulse_go(-11'sd5);
        wait_idle(200, "mid");
        chk("mid_position", longint'(i.O_position), 6);
        chk("mid_psen",     psen_cnt - p0, 4);

        // spurious psdone in IDLE
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_position", longint'(i.O_position), 6);
        chk("spur_busy",     longint'(i.O_busy), 0);

        // +1500 on the 12-bit instance clamps to +1023
        i2.I_target = 12'sd1500;
        i2.I_go     = 1'b1;
        @(negedge clk);
        i2.I_go     = 1'b0;
        chk("clamp_busy", longint'(i2.O_busy), 1);
        k = 0;
        while (i2.O_busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("clamp_idle_wait", longint'(i2.O_busy), 0);
        chk("clamp_position",  longint'(i2.O_position), 1023);
        chk("clamp_psen",      psen2_cnt, 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
